wb_scoreboard: RTL and testbench

Parametrised in-order writeback scoreboard for the pd-series cores. It sits beside the core's register-file write port and holds a queue of expected (rd, value) results. Every architectural writeback is compared against the head of that queue, and the block reports pass/fail counts, a mismatch pulse with captured details, and completion. Benches and on-chip self-test use it instead of hand-timed per-instruction register peeks.

---
 rtl/wb_scoreboard.sv | 214 +++++++++++++++++++++
 tb/tb_wb_scoreboard.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//
// In-order writeback scoreboard. It holds a circular queue of expected
// (rd, value) results, compares every architectural register-file writeback
// against the queue head, and reports pass/fail counts, a one-cycle mismatch
// pulse with the captured fields of the last failure, and completion.
//
// Optional feature macro: CHK_TIMEOUT_EN. When it is defined, a watchdog
// counts RUN cycles without a writeback while entries are pending. On expiry
// it flags timeout, charges every pending entry as a failure, flushes the
// queue and ends the run. When it is undefined, timeout is tied to 0.
//
// Ports:
//   clk                      clock, rising edge
//   reset                    asynchronous, active-low reset
//   start                    one-cycle pulse: IDLE->RUN, or DONE->RUN with clear
//   exp_valid/exp_ready      expected-entry handshake
//   exp_rd, exp_data         expected destination register and value
//   wb_en, wb_rd, wb_data    core register-file write port
//   busy, done               state is RUN / state is DONE
//   mismatch                 one-cycle pulse per failed compare
//   mism_rd_got/mism_rd_exp  register indices of the last failure
//   mism_got/mism_exp        values of the last failure
//   pass_count, fail_count   saturating result counters
//   timeout                  sticky watchdog flag
module wb_scoreboard #(
  parameter int DWIDTH  = 32,
  parameter int RWIDTH  = 5,
  parameter int DEPTH   = 16,
  parameter int CWIDTH  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [RWIDTH-1:0] exp_rd,
  input  logic [DWIDTH-1:0] exp_data,
  input  logic              wb_en,
  input  logic [RWIDTH-1:0] wb_rd,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [RWIDTH-1:0] mism_rd_got,
  output logic [RWIDTH-1:0] mism_rd_exp,
  output logic [DWIDTH-1:0] mism_got,
  output logic [DWIDTH-1:0] mism_exp,
  output logic [CWIDTH-1:0] pass_count,
  output logic [CWIDTH-1:0] fail_count,
  output logic              timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [RWIDTH-1:0] mem_rd   [DEPTH];
  logic [DWIDTH-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, flush, clear;
  logic              wb_evt_p0, have_head_p0, head_match_p0;
  logic              pop_p0, pass_p0, fail_p0;
  logic [RWIDTH-1:0] head_rd_p0;
  logic [DWIDTH-1:0] head_data_p0;

  // Saturating add into a result counter.
  function automatic logic [CWIDTH-1:0] sat_add(input logic [CWIDTH-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [CWIDTH:0] sum;
    sum = {1'b0, a} + (CWIDTH+1)'(b);
    return sum[CWIDTH] ? {CWIDTH{1'b1}} : sum[CWIDTH-1:0];
  endfunction

  // Ready looks only at the registered occupancy, never at a same-cycle pop.
  assign exp_ready = (count_q < FULL_C) && (state_q != S_DONE);
  assign push      = exp_valid && exp_ready;
  assign clear     = (state_q == S_DONE) && start;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  // ---- stage p0: compare the writeback against the queue head ----
  // An empty queue presents zero expected fields, which is what an
  // unexpected write (RUN, empty) or any write in DONE must capture.
  assign wb_evt_p0     = wb_en && (wb_rd != '0);
  assign have_head_p0  = (count_q != '0);
  assign head_rd_p0    = have_head_p0 ? mem_rd[rd_ptr]   : '0;
  assign head_data_p0  = have_head_p0 ? mem_data[rd_ptr] : '0;
  assign head_match_p0 = have_head_p0 && (wb_rd == head_rd_p0) &&
                         (wb_data == head_data_p0);
  assign pop_p0        = (state_q == S_RUN) && wb_evt_p0 && have_head_p0;
  assign pass_p0       = pop_p0 && head_match_p0;
  // A start in DONE takes priority over a coincident writeback.
  assign fail_p0       = wb_evt_p0 &&
                         (((state_q == S_RUN) && !head_match_p0) ||
                          ((state_q == S_DONE) && !start));

`ifdef CHK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt_q;
  logic          idle_wait, tmo_q;

  // Expiry fires on the TIMEOUT-th consecutive idle cycle with entries pending.
  assign idle_wait = (state_q == S_RUN) && have_head_p0 && !wb_evt_p0;
  assign flush     = idle_wait && (tcnt_q == TMO_LAST);
  assign timeout   = tmo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= (idle_wait && !flush) ? tcnt_q + 1'b1 : '0;
      if (clear)      tmo_q <= 1'b0;
      else if (flush) tmo_q <= 1'b1;
    end
  end
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT > 0);
  assign flush      = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(push) - CNT_W'(pop_p0);
  end

  // RUN ends once the queue drains (post-pop) and nothing more is offered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (flush || ((count_d == '0) && !exp_valid)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop_p0) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= exp_rd;
      mem_data[wr_ptr] <= exp_data;
    end
  end

  // ---- stage p1: registered results, visible the cycle after the write ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch    <= 1'b0;
      pass_count  <= '0;
      fail_count  <= '0;
      mism_rd_got <= '0;
      mism_rd_exp <= '0;
      mism_got    <= '0;
      mism_exp    <= '0;
    end else begin
      mismatch <= fail_p0;
      if (clear) begin
        pass_count  <= '0;
        fail_count  <= '0;
        mism_rd_got <= '0;
        mism_rd_exp <= '0;
        mism_got    <= '0;
        mism_exp    <= '0;
      end else begin
        if (pass_p0) pass_count <= sat_add(pass_count, CNT_W'(1));
        if (flush)        fail_count <= sat_add(fail_count, count_q);
        else if (fail_p0) fail_count <= sat_add(fail_count, CNT_W'(1));
        if (fail_p0) begin
          mism_rd_got <= wb_rd;
          mism_rd_exp <= head_rd_p0;
          mism_got    <= wb_data;
          mism_exp    <= head_data_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
`timescale 1ns/1ps
// Self-checking bench for wb_scoreboard: a queue-based reference model is
// stepped on every rising edge and all outputs are compared to it on every
// falling edge; directed scenarios add literal expectations, then a long
// randomized phase (with occasional asynchronous resets) follows.
module tb_wb_scoreboard;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int TMO   = 64;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          exp_valid = 1'b0;
  logic [RW-1:0] exp_rd = '0;
  logic [DW-1:0] exp_data = '0;
  logic          wb_en = 1'b0;
  logic [RW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;
  logic          exp_ready, busy, done, mismatch, timeout;
  logic [RW-1:0] mism_rd_got, mism_rd_exp;
  logic [DW-1:0] mism_got, mism_exp;
  logic [CW-1:0] pass_count, fail_count;

  wb_scoreboard #(
    .DWIDTH(DW), .RWIDTH(RW), .DEPTH(DEPTH), .CWIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_rd(exp_rd), .exp_data(exp_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .done(done), .mismatch(mismatch),
    .mism_rd_got(mism_rd_got), .mism_rd_exp(mism_rd_exp),
    .mism_got(mism_got), .mism_exp(mism_exp),
    .pass_count(pass_count), .fail_count(fail_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  int            m_state;   // 0 idle, 1 run, 2 done
  int            m_pass, m_fail, m_idle;
  bit            m_mism, m_tmo;
  logic [RW-1:0] m_rd_got, m_rd_exp;
  logic [DW-1:0] m_got, m_exp;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_mism = 1'b0; m_tmo = 1'b0; m_idle = 0;
    m_rd_got = '0; m_rd_exp = '0; m_got = '0; m_exp = '0;
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    model_clear();
  endtask

  task automatic model_fail(input logic [RW-1:0] rg, input logic [RW-1:0] re,
                            input logic [DW-1:0] dg, input logic [DW-1:0] de);
    m_fail = sat(m_fail + 1);
    m_mism = 1'b1;
    m_rd_got = rg; m_rd_exp = re; m_got = dg; m_exp = de;
  endtask

  task automatic model_step();
    bit   ready, pushed, evt, fire;
    ent_t h, e;
    if (!reset) begin
      model_reset();
      return;
    end
    ready  = (q.size() < DEPTH) && (m_state != 2);
    pushed = exp_valid && ready;
    evt    = wb_en && (wb_rd != '0);
    e.rd   = exp_rd;
    e.data = exp_data;
    m_mism = 1'b0;
    fire   = 1'b0;
    case (m_state)
      0: begin
        if (pushed) q.push_back(e);
        if (start) m_state = 1;
      end
      1: begin
`ifdef CHK_TIMEOUT_EN
        if (q.size() > 0 && !evt) begin
          m_idle++;
          if (m_idle == TMO) fire = 1'b1;
        end else begin
          m_idle = 0;
        end
`endif
        if (fire) begin
          m_tmo  = 1'b1;
          m_fail = sat(m_fail + q.size());
          q.delete();
          m_idle = 0;
          m_state = 2;
        end else begin
          if (evt) begin
            if (q.size() > 0) begin
              h = q.pop_front();
              if (h.rd == wb_rd && h.data == wb_data) m_pass = sat(m_pass + 1);
              else model_fail(wb_rd, h.rd, wb_data, h.data);
            end else begin
              model_fail(wb_rd, '0, wb_data, '0);
            end
          end
          if (pushed) q.push_back(e);
          if (q.size() == 0 && !exp_valid) m_state = 2;
        end
      end
      default: begin
        if (start) begin
          model_clear();
          m_state = 1;
        end else if (evt) begin
          model_fail(wb_rd, '0, wb_data, '0);
        end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic check_outputs();
    chk("exp_ready",   64'(exp_ready),   64'((q.size() < DEPTH) && (m_state != 2)));
    chk("busy",        64'(busy),        64'(m_state == 1));
    chk("done",        64'(done),        64'(m_state == 2));
    chk("mismatch",    64'(mismatch),    64'(m_mism));
    chk("mism_rd_got", 64'(mism_rd_got), 64'(m_rd_got));
    chk("mism_rd_exp", 64'(mism_rd_exp), 64'(m_rd_exp));
    chk("mism_got",    64'(mism_got),    64'(m_got));
    chk("mism_exp",    64'(mism_exp),    64'(m_exp));
    chk("pass_count",  64'(pass_count),  64'(m_pass));
    chk("fail_count",  64'(fail_count),  64'(m_fail));
    chk("timeout",     64'(timeout),     64'(m_tmo));
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    start = 1'b0; exp_valid = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs();
    cycle();
    reset = 1'b1;
  endtask

  task automatic push(input int rd, input logic [DW-1:0] d);
    exp_valid = 1'b1; exp_rd = RW'(rd); exp_data = d;
    cycle();
    exp_valid = 1'b0;
  endtask

  task automatic wb(input int rd, input logic [DW-1:0] d);
    wb_en = 1'b1; wb_rd = RW'(rd); wb_data = d;
    cycle();
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    model_reset();

    // Reset state
    do_reset();
    chk("rst_exp_ready", 64'(exp_ready), 64'(1));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_done",      64'(done),      64'(0));
    chk("rst_fail",      64'(fail_count), 64'(0));

    // In-order matching writebacks
    push(10, 100); push(11, 150); push(13, 32'hFFFFFFCE); push(12, 250);
    pulse_start();
    chk("t1_busy", 64'(busy), 64'(1));
    wb(10, 100); wb(11, 150); wb(13, 32'hFFFFFFCE);
    chk("t1_not_done", 64'(done), 64'(0));
    wb(12, 250);
    chk("t1_done", 64'(done), 64'(1));
    chk("t1_pass", 64'(pass_count), 64'(4));
    chk("t1_fail", 64'(fail_count), 64'(0));

    // Single data mismatch
    do_reset();
    push(22, 32'hDEADBEEF);
    pulse_start();
    wb(22, 32'hDEADBEEE);
    chk("t2_mismatch", 64'(mismatch), 64'(1));
    chk("t2_got",      64'(mism_got), 64'(32'hDEADBEEE));
    chk("t2_exp",      64'(mism_exp), 64'(32'hDEADBEEF));
    chk("t2_rd_exp",   64'(mism_rd_exp), 64'(22));
    chk("t2_fail",     64'(fail_count), 64'(1));
    cycle();
    chk("t2_pulse_end", 64'(mismatch), 64'(0));
    chk("t2_hold",      64'(mism_got), 64'(32'hDEADBEEE));

    // Full queue, refused 17th entry, same-cycle push/pop at count 8
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(i + 1, 32'(1000 + i));
    chk("t3_full_ready", 64'(exp_ready), 64'(0));
    push(31, 32'hBAD);
    chk("t3_still_full", 64'(exp_ready), 64'(0));
    pulse_start();
    for (int i = 0; i < 8; i++) wb(i + 1, 32'(1000 + i));
    exp_valid = 1'b1; exp_rd = RW'(30); exp_data = 777;
    wb(9, 1008);
    exp_valid = 1'b0;
    for (int i = 9; i < DEPTH; i++) wb(i + 1, 32'(1000 + i));
    chk("t3_pending", 64'(done), 64'(0));
    wb(30, 777);
    chk("t3_done",     64'(done), 64'(1));
    chk("t3_fail",     64'(fail_count), 64'(0));
    chk("t3_pass_sat", 64'(pass_count), 64'(CMAX));

    // x0 write ignored, writes in DONE fail, saturation, restart clears
    do_reset();
    push(1, 1);
    pulse_start();
    wb(0, 32'h55);
    chk("t4_x0_pass", 64'(pass_count), 64'(0));
    chk("t4_x0_fail", 64'(fail_count), 64'(0));
    chk("t4_x0_busy", 64'(busy), 64'(1));
    wb(1, 1);
    chk("t4_done", 64'(done), 64'(1));
    wb(5, 7);
    chk("t4_done_fail", 64'(fail_count), 64'(1));
    chk("t4_done_mism", 64'(mismatch), 64'(1));
    chk("t4_done_got",  64'(mism_got), 64'(7));
    chk("t4_done_exp",  64'(mism_exp), 64'(0));
    for (int i = 0; i < 20; i++) wb(5, 32'(i));
    chk("t4_fail_sat", 64'(fail_count), 64'(CMAX));
    pulse_start();
    chk("t4_clr_fail", 64'(fail_count), 64'(0));
    chk("t4_clr_pass", 64'(pass_count), 64'(0));
    chk("t4_clr_got",  64'(mism_got), 64'(0));
    chk("t4_rerun",    64'(busy), 64'(1));
    cycle();
    chk("t4_redone", 64'(done), 64'(1));

    // Watchdog
    do_reset();
    push(1, 11); push(2, 22); push(3, 33);
    pulse_start();
    repeat (TMO - 1) cycle();
    chk("t5_pre_tmo", 64'(timeout), 64'(0));
    chk("t5_pre_busy", 64'(busy), 64'(1));
    cycle();
`ifdef CHK_TIMEOUT_EN
    chk("t5_timeout", 64'(timeout), 64'(1));
    chk("t5_fail",    64'(fail_count), 64'(3));
    chk("t5_done",    64'(done), 64'(1));
`else
    repeat (40) cycle();
    chk("t5_waits", 64'(busy), 64'(1));
    chk("t5_no_tmo", 64'(timeout), 64'(0));
`endif

    // Asynchronous reset mid-RUN, then start on an empty queue
    do_reset();
    for (int i = 0; i < 6; i++) push(i + 1, 32'(i));
    pulse_start();
    wb(3, 0);
    chk("t6_pre_fail", 64'(fail_count), 64'(1));
    #2 reset = 1'b0;
    #1 model_reset();
    chk("t6_async_busy",  64'(busy), 64'(0));
    chk("t6_async_fail",  64'(fail_count), 64'(0));
    chk("t6_async_got",   64'(mism_got), 64'(0));
    chk("t6_async_ready", 64'(exp_ready), 64'(1));
    check_outputs();
    cycle();
    reset = 1'b1;
    pulse_start();
    chk("t6_busy", 64'(busy), 64'(1));
    cycle();
    chk("t6_done", 64'(done), 64'(1));

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      idle_inputs();
      start     = ($urandom_range(0, 99) < 5);
      exp_valid = ($urandom_range(0, 1) == 1);
      exp_rd    = RW'($urandom);
      exp_data  = DW'($urandom);
      if (!start && $urandom_range(0, 99) < 45) begin
        wb_en = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
          wb_rd   = q[0].rd;
          wb_data = q[0].data;
          if ($urandom_range(0, 9) == 0) wb_data = wb_data ^ DW'(1);
        end else begin
          wb_rd   = ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
          wb_data = DW'($urandom);
        end
      end
      cycle();
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
